// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   ALU in which AND/OR/ADD/SUB/XOR/EQ/SLT finish in a single edge, and shifts
//   move one bit per clock through an internal working register. An operation
//   is accepted only from IDLE. Its operands and opcode are captured at the
//   start edge. The result appears together with a one-cycle done pulse.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   operation request, sampled only while busy=0
//   Operation  in   4-bit opcode (AND,OR,ADD,SUB,XOR,SLL,SRL,SRA,EQ,SLT)
//   SrcA       in   operand A
//   SrcB       in   operand B; SrcB[SW-1:0] is the shift amount
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle completion pulse
//   ALUResult  out  registered result, held until the next completion
//   Zero       out  registered (ALUResult == 0)
// -----------------------------------------------------------------------------
module alu_multicycle #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
);

   localparam int SW = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1001;

   localparam logic [SW-1:0] CNT_ONE = SW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] work_q, work_d;
   logic [SW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Single-edge result. A shift reaches this function only with a shift
   // amount of 0, so it passes operand A through unchanged.
   function automatic logic [DATA_WIDTH-1:0] alu_comb(input logic [3:0]            op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_AND:                 r = a & b;
         OP_OR:                  r = a | b;
         OP_ADD:                 r = a + b;
         OP_SUB:                 r = a - b;
         OP_XOR:                 r = a ^ b;
         OP_SLL, OP_SRL, OP_SRA: r = a;
         OP_EQ:                  r = DATA_WIDTH'(a == b);
         OP_SLT:                 r = DATA_WIDTH'($signed(a) < $signed(b));
         default:                r = '0;
      endcase
      return r;
   endfunction

   // One bit of shift per clock.
   function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [3:0]            op,
                                                       input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = {w[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, w[DATA_WIDTH-1:1]};
         OP_SRA:  r = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case statement can leave a value unassigned and infer a latch.
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = Operation;
               if (is_shift(Operation) && (SrcB[SW-1:0] != '0)) begin
                  work_d  = SrcA;
                  cnt_d   = SrcB[SW-1:0];
                  state_d = S_SHIFT;
               end else begin
                  result_d = alu_comb(Operation, SrcA, SrcB);
                  zero_d   = (result_d == '0);
                  state_d  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            work_d = shift_one(op_q, work_q);
            cnt_d  = cnt_q - CNT_ONE;
            // The result register is loaded only when the last bit has moved,
            // so ALUResult keeps its previous value while the shift runs.
            if (cnt_q == CNT_ONE) begin
               result_d = work_d;
               zero_d   = (work_d == '0);
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples the
         // pre-edge values regardless of statement order.
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign ALUResult = result_q;
   assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle. It runs a table of directed
//   vectors, hand-written sequences for start-held and reset-abort cases,
//   and randomized operations checked against a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   Operation;
   logic [W-1:0] SrcA, SrcB;
   logic         busy, done, Zero;
   logic [W-1:0] ALUResult;

   int n_checks = 0;
   int n_fail   = 0;

   alu_multicycle #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .busy      (busy),
      .done      (done),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      int           lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the result comes from ordinary operators. Latency is
   // one edge, plus one edge per bit of nonzero shift.
   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output int lat);
      int sh;
      sh = int'(b % W);
      case (op)
         4'd0:    r = a & b;
         4'd1:    r = a | b;
         4'd2:    r = a + b;
         4'd3:    r = a - b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << sh;
         4'd6:    r = a >> sh;
         4'd7:    r = $signed(a) >>> sh;
         4'd8:    r = (a == b) ? 1 : 0;
         4'd9:    r = ($signed(a) < $signed(b)) ? 1 : 0;
         default: r = '0;
      endcase
      lat = ((op >= 4'd5) && (op <= 4'd7) && (sh != 0)) ? sh + 1 : 1;
   endtask

   // Issue one operation from IDLE and return the result, Zero and the number
   // of edges from the start-sampling edge to done. The task then waits one
   // more edge so the DUT is back in IDLE.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic z, output int lat);
      @(negedge clk);
      Operation = op; SrcA = a; SrcB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = ALUResult;
      z = Zero;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] r, er, prev;
      logic         z;
      int           lat, elat, dcount, changed;

      vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
      vecs[1]  = '{4'b0011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1};
      vecs[2]  = '{4'b0111, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32};
      vecs[3]  = '{4'b0110, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32};
      vecs[4]  = '{4'b0101, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1};
      vecs[5]  = '{4'b0101, 32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0, 5};
      vecs[6]  = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
      vecs[7]  = '{4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1'b0, 1};
      vecs[8]  = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1};
      vecs[9]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
      vecs[10] = '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1};
      vecs[11] = '{4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1};
      vecs[12] = '{4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
      vecs[13] = '{4'b1000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1};
      vecs[14] = '{4'b0111, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000, 1'b0, 5};
      vecs[15] = '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};

      reset = 1'b0; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(ALUResult), 64'd0);
      check("reset_zero", 64'(Zero), 64'd1);
      reset = 1'b1;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
         check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].res));
         check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].zero));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      // Start is held high through a 10-bit SRL, and the operands change after capture
      prev = ALUResult;
      @(negedge clk);
      Operation = 4'b0110; SrcA = 32'h8000_0000; SrcB = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      Operation = 4'b0010; SrcA = 32'hFFFF_FFFF; SrcB = 32'd3;
      check("hold_busy_after_start", 64'(busy), 64'd1);
      dcount = 0; changed = 0;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk); #1;
         if (done) dcount++;
         if (ALUResult !== prev) changed++;
      end
      check("hold_no_early_done", 64'(dcount), 64'd0);
      check("hold_result_frozen", 64'(changed), 64'd0);
      @(posedge clk); #1;
      check("hold_done_e10", 64'(done), 64'd1);
      check("hold_result", 64'(ALUResult), 64'h0020_0000);
      @(posedge clk); #1;
      check("hold_done_cleared", 64'(done), 64'd0);
      check("hold_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("hold_next_done", 64'(done), 64'd1);
      check("hold_next_result", 64'(ALUResult), 64'h0000_0002);
      start = 1'b0;
      @(posedge clk); #1;

      // Reset is pulsed during a 20-bit shift, before edge 7
      @(negedge clk);
      Operation = 4'b0101; SrcA = 32'h0000_0001; SrcB = 32'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("abort_busy_pre", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(ALUResult), 64'd0);
      check("abort_zero", 64'(Zero), 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      dcount = 0;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      check("abort_no_done", 64'(dcount), 64'd0);
      check("abort_result_after", 64'(ALUResult), 64'd0);
      check("abort_zero_after", 64'(Zero), 64'd1);
      do_op(4'b0010, 32'd2, 32'd3, r, z, lat);
      check("after_abort_add", 64'(r), 64'd5);

      // Start is asserted already at the first edge after reset release
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      Operation = 4'b0010; SrcA = 32'd2; SrcB = 32'd3; start = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("first_edge_done", 64'(done), 64'd1);
      check("first_edge_result", 64'(ALUResult), 64'd5);
      @(posedge clk); #1;

      // Randomized operations checked against the model
      for (int i = 0; i < 300; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = $urandom();
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
         model(op, a, b, er, elat);
         do_op(op, a, b, r, z, lat);
         check($sformatf("rnd%0d_op%0d_result", i, op), 64'(r), 64'(er));
         check($sformatf("rnd%0d_op%0d_zero", i, op), 64'(z), 64'(er == '0));
         check($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat), 64'(elat));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
